// File: rtl/lcd_frame_scheduler_pkg.sv
// Shared constants, state encoding and char-slice helper for the
// LCD frame scheduler.
package lcd_frame_scheduler_pkg;

    localparam int LCD_CHARS = 16;
    localparam int FRAME_W = 8 * LCD_CHARS;

    localparam logic [7:0] FONT_NONE = 8'h00;
    localparam logic [7:0] FONT_BLANK = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Char 0 sits in the most significant byte of a frame.
    function automatic logic [7:0] char_at(
        input logic [FRAME_W-1:0] frame,
        input logic [3:0] pos
    );
        return frame[FRAME_W-1-8*int'(pos) -: 8];
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_timer.sv
// lcd_refresh_timer: loadable down-counter that saturates at zero
// and flags expiry while the count is zero.
module lcd_refresh_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Arbitrates the LCD char writer between screen sources: snapshots the
// selected 16-char frame and streams it byte by byte over valid/ready.
module lcd_frame_scheduler
    import lcd_frame_scheduler_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter int         SEL_W       = 2,
    parameter int         REFRESH_CYC = 1000000,
    parameter logic [7:0] BLANK_CHAR  = FONT_BLANK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           src_sel,
    input  logic [NUM_SRC*FRAME_W-1:0] src_data,
    input  logic                       force_refresh,
    input  logic                       lcd_ready,
    output logic [7:0]                 lcd_byte,
    output logic [3:0]                 lcd_addr,
    output logic                       lcd_valid,
    output logic                       frame_done,
    output logic                       busy,
    output logic [SEL_W-1:0]           cur_src
);

    localparam int TW = $clog2(REFRESH_CYC + 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(REFRESH_CYC - 1);

    state_t             state;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] sel_frame;
    logic               pending;
    logic               expired;
    logic               trigger;
    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               timer_dec;
    logic               late_req;

    // Out-of-range selections show a blank screen.
    always_comb begin
        sel_frame = {LCD_CHARS{BLANK_CHAR}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                sel_frame = src_data[FRAME_W*k +: FRAME_W];
            end
        end
    end

    assign trigger = expired || pending || force_refresh
                   || (src_sel != cur_src);

    assign timer_load = (state == ST_GAP)
                      || (state == ST_IDLE && trigger);
    assign timer_val  = (state == ST_GAP) ? GAP_LOAD : '0;
    assign timer_dec  = (state == ST_IDLE);

    assign late_req = (state == ST_SEND || state == ST_GAP)
                   && (force_refresh || src_sel != cur_src);

    lcd_refresh_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shadow     <= {LCD_CHARS{BLANK_CHAR}};
            pending    <= 1'b0;
            cur_src    <= '0;
            lcd_valid  <= 1'b0;
            lcd_byte   <= FONT_NONE;
            lcd_addr   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Requests during a frame are deferred, never abort it.
            if (late_req) begin
                pending <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state <= ST_LATCH;
                        busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    shadow    <= sel_frame;
                    cur_src   <= src_sel;
                    pending   <= force_refresh;
                    lcd_addr  <= '0;
                    lcd_byte  <= char_at(sel_frame, 4'd0);
                    lcd_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (lcd_ready) begin
                        if (lcd_addr == 4'd15) begin
                            lcd_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_GAP;
                        end else begin
                            lcd_addr <= lcd_addr + 4'd1;
                            lcd_byte <= char_at(shadow, lcd_addr + 4'd1);
                        end
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
